// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: RAM geometry, printable-ASCII bounds and the PRGA
// state encoding used by the keystream/decrypt stage.
package arc4_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [7:0] ASCII_LO = 8'h20;
    localparam logic [7:0] ASCII_HI = 8'h7E;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        LD_LEN,
        WR_LEN,
        RD_SI,
        LD_SI,
        RD_SJ,
        LD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        LD_PAD,
        WR_PT,
        DONE
    } prga_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation + decrypt stage: swaps S, builds the keystream
// and writes PT = CT ^ pad. Optional early exit on non-printable output: PRGA_ASCII_CHECK_EN.
module prga #(
    parameter int ADDR_W = arc4_pkg::ADDR_W,
    parameter int DATA_W = arc4_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_wrdata,
    output logic              pt_wren
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic              ascii_ok
`endif
);
    import arc4_pkg::*;

    if (ADDR_W != 8 || DATA_W != 8) begin : g_width_check
        $fatal(1, "prga: ADDR_W and DATA_W must both be 8");
    end

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    prga_state_t       state_q, state_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] si_q, si_d;
    logic [DATA_W-1:0] sj_q, sj_d;
    logic [DATA_W-1:0] pad_q, pad_d;
    logic [DATA_W-1:0] ctb_q, ctb_d;
    logic [DATA_W-1:0] pt_byte;
`ifdef PRGA_ASCII_CHECK_EN
    logic              ascii_ok_q, ascii_ok_d;
    assign ascii_ok = ascii_ok_q;
`endif

    assign rdy     = rdy_q;
    assign pt_byte = pad_q ^ ctb_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        rdy_d     = rdy_q;
        len_d     = len_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        pad_d     = pad_q;
        ctb_d     = ctb_q;
`ifdef PRGA_ASCII_CHECK_EN
        ascii_ok_d = ascii_ok_q;
`endif
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && rdy_q) begin
                    state_d = RD_LEN;
                    rdy_d   = 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
                    ascii_ok_d = 1'b1;
`endif
                end
            end
            RD_LEN: begin
                ct_addr = '0;
                state_d = LD_LEN;
            end
            LD_LEN: begin
                len_d   = ct_rddata;
                i_d     = '0;
                j_d     = '0;
                k_d     = ADDR_ONE;
                state_d = WR_LEN;
            end
            WR_LEN: begin
                pt_addr   = '0;
                pt_wrdata = len_q;
                pt_wren   = 1'b1;
                state_d   = (len_q != '0) ? RD_SI : DONE;
            end
            RD_SI: begin
                i_d     = i_q + ADDR_ONE;
                s_addr  = i_q + ADDR_ONE;
                state_d = LD_SI;
            end
            LD_SI: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                s_addr  = j_q;
                state_d = LD_SJ;
            end
            LD_SJ: begin
                sj_d    = s_rddata;
                state_d = WR_SI;
            end
            // Both swap writes always happen; with i==j the second restores S[i].
            WR_SI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = WR_SJ;
            end
            WR_SJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = RD_PAD;
            end
            RD_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
                state_d = LD_PAD;
            end
            LD_PAD: begin
                pad_d   = s_rddata;
                ctb_d   = ct_rddata;
                state_d = WR_PT;
            end
            WR_PT: begin
                pt_addr   = k_q;
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
                // k stops at len so a 255-byte message never wraps it.
                if (k_q == len_q) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + ADDR_ONE;
                    state_d = RD_SI;
                end
`ifdef PRGA_ASCII_CHECK_EN
                if (!is_printable(pt_byte)) begin
                    ascii_ok_d = 1'b0;
                    state_d    = DONE;
                end
`endif
            end
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            len_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            pad_q   <= '0;
            ctb_q   <= '0;
`ifdef PRGA_ASCII_CHECK_EN
            ascii_ok_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            len_q   <= len_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            pad_q   <= pad_d;
            ctb_q   <= ctb_d;
`ifdef PRGA_ASCII_CHECK_EN
            ascii_ok_q <= ascii_ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: behavioural RAMs plus a plain ARC4 PRGA model.
// Also covers the PRGA_ASCII_CHECK_EN build when that macro is defined.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst, en, rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic       pt_wren;
`ifdef PRGA_ASCII_CHECK_EN
    logic       ascii_ok;
`endif

    always #5 clk = ~clk;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
`ifdef PRGA_ASCII_CHECK_EN
        ,
        .ascii_ok  (ascii_ok)
`endif
    );

    // RAMs with one-cycle read latency; preload arrives in one edge via load_* flags.
    logic [7:0] s_mem [256];
    logic [7:0] ct_mem[256];
    logic [7:0] pt_mem[256];
    logic [7:0] s_init [256];
    logic [7:0] ct_init[256];
    logic       load_s = 1'b0;
    logic       load_ct = 1'b0;
    int         s_wr_cnt = 0;
    int         pt_wr_cnt = 0;

    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt      <= s_wr_cnt + 1;
        end
        if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
            pt_wr_cnt       <= pt_wr_cnt + 1;
        end
        if (load_s)
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        if (load_ct) begin
            for (int a = 0; a < 256; a++) begin
                ct_mem[a] <= ct_init[a];
                pt_mem[a] <= 8'hEE;
            end
            s_wr_cnt  <= 0;
            pt_wr_cnt <= 0;
        end
    end

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: textbook ARC4 PRGA over arrays.
    logic [7:0] m_s [256];
    logic [7:0] m_pt[256];
    bit         m_ascii_ok;

    task automatic model_run(input int max_bytes, output int n_done);
        int         len, i, j;
        logic [7:0] t, pad, b;
        len     = int'(ct_init[0]);
        i       = 0;
        j       = 0;
        n_done  = 0;
        m_pt[0] = ct_init[0];
        for (int k = 1; k <= len && k <= max_bytes; k++) begin
            i       = (i + 1) % 256;
            j       = (j + int'(m_s[i])) % 256;
            t       = m_s[i];
            m_s[i]  = m_s[j];
            m_s[j]  = t;
            pad     = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
            b       = ct_init[k] ^ pad;
            m_pt[k] = b;
            n_done  = k;
`ifdef PRGA_ASCII_CHECK_EN
            if (b < 8'h20 || b > 8'h7E) begin
                m_ascii_ok = 1'b0;
                break;
            end
`endif
        end
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic set_shuffled();
        logic [7:0] t;
        int         r;
        set_identity();
        for (int a = 255; a > 0; a--) begin
            r         = int'($urandom_range(a, 0));
            t         = s_init[a];
            s_init[a] = s_init[r];
            s_init[r] = t;
        end
    endtask

    task automatic load_mems(input bit with_s);
        @(negedge clk);
        load_s  = with_s;
        load_ct = 1'b1;
        @(posedge clk);
        #1;
        load_s  = 1'b0;
        load_ct = 1'b0;
    endtask

    // Start a run and count edges after the accepting one until rdy returns.
    task automatic start_and_wait(input bit glitch, output int cycles);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en     = 1'b0;
        cycles = 0;
        while (rdy !== 1'b1 && cycles < 3000) begin
            en = glitch && (cycles == 6 || cycles == 7);
            @(posedge clk);
            #1;
            cycles++;
        end
        en = 1'b0;
    endtask

    task automatic run_case(input string tag, input bit reload_s, input bit glitch,
                            output int cycles);
        int n, bad;
        if (reload_s)
            for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        for (int a = 0; a < 256; a++) m_pt[a] = 8'hEE;
        m_ascii_ok = 1'b1;
        model_run(256, n);
        load_mems(reload_s);
        check({tag, "/rdy_idle"}, int'(rdy), 1);
        start_and_wait(glitch, cycles);
        check({tag, "/cycles"}, cycles, 4 + 9 * n);
        bad = 0;
        for (int a = 0; a < 256; a++) if (pt_mem[a] !== m_pt[a]) bad++;
        check({tag, "/pt_bad"}, bad, 0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
        check({tag, "/s_bad"}, bad, 0);
        check({tag, "/s_wr_cnt"}, s_wr_cnt, 2 * n);
        check({tag, "/pt_wr_cnt"}, pt_wr_cnt, n + 1);
`ifdef PRGA_ASCII_CHECK_EN
        check({tag, "/ascii_ok"}, int'(ascii_ok), int'(m_ascii_ok));
`endif
        repeat (2) @(posedge clk);
        #1;
        check({tag, "/rdy_stays"}, int'(rdy), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, bad;
        rst = 1'b1;
        en  = 1'b0;
        set_identity();
        for (int a = 0; a < 256; a++) ct_init[a] = 8'h00;
        load_mems(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset/rdy", int'(rdy), 1);
        check("reset/s_wren", int'(s_wren), 0);
        check("reset/pt_wren", int'(pt_wren), 0);
        check("reset/s_addr", int'(s_addr), 0);
        check("reset/s_wrdata", int'(s_wrdata), 0);
        check("reset/ct_addr", int'(ct_addr), 0);
        check("reset/pt_addr", int'(pt_addr), 0);
        check("reset/pt_wrdata", int'(pt_wrdata), 0);
`ifdef PRGA_ASCII_CHECK_EN
        check("reset/ascii_ok", int'(ascii_ok), 1);
`endif

        // One byte over identity S: pad = S[2] = 02.
        set_identity();
        ct_init[0] = 8'h01;
        ct_init[1] = 8'h41;
        run_case("one_byte", 1'b1, 1'b0, cyc);
        check("one_byte/pt0", int'(pt_mem[0]), 'h01);
        check("one_byte/pt1", int'(pt_mem[1]), 'h43);
        check("one_byte/cyc13", cyc, 13);

        // Two bytes: second byte swaps S[2] and S[3], pad = S[5].
        set_identity();
        ct_init[0] = 8'h02;
        ct_init[1] = 8'h41;
        ct_init[2] = 8'h00;
        run_case("two_byte", 1'b1, 1'b1, cyc);
        check("two_byte/pt1", int'(pt_mem[1]), 'h43);
        check("two_byte/pt2", int'(pt_mem[2]), 'h05);
        check("two_byte/s2", int'(s_mem[2]), 'h03);
        check("two_byte/s3", int'(s_mem[3]), 'h02);

        // Empty message.
        set_identity();
        ct_init[0] = 8'h00;
        run_case("empty", 1'b1, 1'b0, cyc);
        check("empty/pt0", int'(pt_mem[0]), 'h00);
        check("empty/cyc4", cyc, 4);

        // Longest message: j wraps, k must stop at 255.
        set_identity();
        ct_init[0] = 8'hFF;
        for (int k = 1; k < 256; k++) ct_init[k] = 8'($urandom);
        run_case("max_len", 1'b1, 1'b0, cyc);
`ifndef PRGA_ASCII_CHECK_EN
        check("max_len/cyc2299", cyc, 2299);
`endif

`ifdef PRGA_ASCII_CHECK_EN
        set_identity();
        ct_init[0] = 8'h02;
        ct_init[1] = 8'h1E;
        ct_init[2] = 8'h00;
        run_case("ascii_abort", 1'b1, 1'b0, cyc);
        check("ascii_abort/pt1", int'(pt_mem[1]), 'h1C);
        check("ascii_abort/pt2_unwritten", int'(pt_mem[2]), 'hEE);
        check("ascii_abort/ok", int'(ascii_ok), 0);
        check("ascii_abort/cyc13", cyc, 13);
`endif

        // Reset while byte 3 of a 5-byte run is between its reads and its swap.
        set_identity();
        ct_init[0] = 8'h05;
        for (int k = 1; k <= 5; k++) ct_init[k] = 8'h40;
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        m_ascii_ok = 1'b1;
        model_run(2, n);
        load_mems(1'b1);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst/rdy", int'(rdy), 1);
        check("midrst/s_wren", int'(s_wren), 0);
        check("midrst/pt_wren", int'(pt_wren), 0);
        rst = 1'b0;
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
        check("midrst/s_after_two", bad, 0);
        ct_init[0] = 8'h06;
        for (int k = 1; k <= 6; k++) ct_init[k] = 8'($urandom);
        run_case("midrst_rerun", 1'b0, 1'b0, cyc);

        // Random permutations and messages.
        for (int t = 0; t < 6; t++) begin
            set_shuffled();
            ct_init[0] = 8'($urandom_range(40, 1));
            for (int k = 1; k < 256; k++) ct_init[k] = 8'($urandom);
            run_case($sformatf("rand%0d", t), 1'b1, t[0], cyc);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
